// File: rtl/ram_bw_hs.sv
// Single-port synchronous RAM with byte-masked writes, a registered read under valid/ready
// back-pressure, and an optional post-reset clear of every word.
module ram_bw_hs #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 10,
   parameter int INIT_CLEAR = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  init_done
);

   localparam int BYTES = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   generate
      if (DATA_W % 8 != 0) begin : g_bad_width
         $fatal(1, "ram_bw_hs: DATA_W must be a multiple of 8");
      end
   endgenerate

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic                r_init_done;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_wr_fire;
   logic                w_rd_fire;

   // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
   // a response transfers where rsp_valid && rsp_ready. A held response blocks new
   // requests of either kind, which keeps reads and writes strictly in order.
   assign req_ready = !rst && (r_state == S_RUN) && r_init_done
                      && (!r_rsp_valid || rsp_ready);
   assign w_wr_fire = req_valid && req_ready && req_we;
   assign w_rd_fire = req_valid && req_ready && !req_we;

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign init_done = r_init_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
         r_clr_cnt   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_init_done <= (INIT_CLEAR != 0) ? 1'b0 : 1'b1;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_clr_cnt <= r_clr_cnt + 1'b1;
               if (r_clr_cnt == '1) begin
                  r_state     <= S_RUN;
                  r_init_done <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_rd_fire) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_mem[req_addr];
               end else if (r_rsp_valid && rsp_ready) begin
                  r_rsp_valid <= 1'b0;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   // Storage has no reset of its own; contents survive rst unless the clear sweep runs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == S_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
         end else if (w_wr_fire) begin
            for (int i = 0; i < BYTES; i++) begin
               if (req_wmask[i]) begin
                  r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
               end
            end
         end
      end
   end

endmodule
